spi_inst_tx: RTL and testbench

SPI_INST_TX -- requirements
Module: spi_inst_tx

---
 rtl/spi_tx_pkg.sv | 15 +
 rtl/sync_fifo.sv | 46 ++++
 rtl/spi_inst_tx.sv | 134 +++++++++++++
 tb/tb_spi_inst_tx.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_tx_pkg.sv
// Shared types and default constants for the SPI word transmitter.
package spi_tx_pkg;

  localparam int unsigned DefDataWidth = 32;
  localparam int unsigned DefFifoDepth = 4;
  localparam int unsigned DefGapCycles = 2;
  localparam int unsigned WordCntWidth = 16;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StGap
  } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers; push while full is allowed when a pop
// happens on the same edge.
module sync_fifo #(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW:0]    wptr_q, rptr_q;
  logic             do_push, do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[PtrW] != rptr_q[PtrW]) &&
                   (wptr_q[PtrW-1:0] == rptr_q[PtrW-1:0]);
  assign rdata_o = mem_q[rptr_q[PtrW-1:0]];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  // Storage needs no reset: the pointers define which entries are valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q[PtrW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/spi_inst_tx.sv
// Buffered SPI transmitter: serialises FIFO words MSB first, one frame per word,
// with a fixed select-high gap between frames.
module spi_inst_tx
  import spi_tx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned FIFO_DEPTH = DefFifoDepth,
  parameter int unsigned GAP_CYCLES = DefGapCycles
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [DATA_WIDTH-1:0]   data_i,
  input  logic                    valid_i,
  output logic                    ready_o,
  output logic                    spi_ss_o,
  output logic                    spi_mosi_o,
  output logic                    busy_o,
  output logic [WordCntWidth-1:0] words_sent_o
);

  localparam int unsigned BitCntW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int unsigned GapCntW = $clog2(GAP_CYCLES + 1);
  localparam logic [BitCntW-1:0] LastBit = BitCntW'(DATA_WIDTH - 1);
  localparam logic [GapCntW-1:0] LastGap = GapCntW'(GAP_CYCLES - 1);

  tx_state_e               state_q, state_d;
  logic [DATA_WIDTH-1:0]   shreg_q, shreg_d;
  logic [BitCntW-1:0]      bit_cnt_q, bit_cnt_d;
  logic [GapCntW-1:0]      gap_cnt_q, gap_cnt_d;
  logic                    ss_q, ss_d;
  logic                    mosi_q, mosi_d;
  logic [WordCntWidth-1:0] words_sent_q;
  logic                    word_done;
  logic                    last_bit, last_gap;

  logic [DATA_WIDTH-1:0]   fifo_rdata;
  logic                    fifo_full, fifo_empty, fifo_push, fifo_pop;

  assign ready_o   = !fifo_full;
  assign fifo_push = valid_i && ready_o;
  assign last_bit  = (bit_cnt_q == LastBit);
  assign last_gap  = (gap_cnt_q == LastGap);
  // Every entry into SHIFT consumes the FIFO head.
  assign fifo_pop  = (state_d == StShift) && (state_q != StShift);

  sync_fifo #(
    .Width (DATA_WIDTH),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (fifo_push),
    .wdata_i (data_i),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (!fifo_empty) state_d = StShift;
      StShift: if (last_bit) state_d = StGap;
      StGap:   if (last_gap) state_d = fifo_empty ? StIdle : StShift;
      default: state_d = StIdle;
    endcase
  end

  // Next values for the registered pins and datapath; the pins are pure flops.
  always_comb begin
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    ss_d      = 1'b1;
    mosi_d    = 1'b0;
    word_done = 1'b0;
    if (fifo_pop) begin
      shreg_d   = fifo_rdata << 1;
      bit_cnt_d = '0;
      ss_d      = 1'b0;
      mosi_d    = fifo_rdata[DATA_WIDTH-1];
    end else if ((state_q == StShift) && !last_bit) begin
      shreg_d   = shreg_q << 1;
      bit_cnt_d = bit_cnt_q + 1'b1;
      ss_d      = 1'b0;
      mosi_d    = shreg_q[DATA_WIDTH-1];
    end
    if ((state_q == StShift) && last_bit) begin
      gap_cnt_d = '0;
      word_done = 1'b1;
    end else if (state_q == StGap) begin
      gap_cnt_d = gap_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      ss_q      <= 1'b1;
      mosi_q    <= 1'b0;
    end else begin
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      ss_q      <= ss_d;
      mosi_q    <= mosi_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      words_sent_q <= '0;
    end else if (word_done) begin
      words_sent_q <= words_sent_q + 1'b1;
    end
  end

  assign spi_ss_o     = ss_q;
  assign spi_mosi_o   = mosi_q;
  assign busy_o       = (state_q != StIdle) || !fifo_empty;
  assign words_sent_o = words_sent_q;

endmodule

// File: tb/tb_spi_inst_tx.sv
// Directed bench for spi_inst_tx with a negedge SPI receiver model on the pins.
module tb_spi_inst_tx;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [31:0] data_i;
  logic        valid_i;
  logic        ready_o;
  logic        spi_ss_o;
  logic        spi_mosi_o;
  logic        busy_o;
  logic [15:0] words_sent_o;

  always #5 clk_i = ~clk_i;

  spi_inst_tx dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .data_i       (data_i),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .spi_ss_o     (spi_ss_o),
    .spi_mosi_o   (spi_mosi_o),
    .busy_o       (busy_o),
    .words_sent_o (words_sent_o)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Receiver model: shifts MOSI while select is low, logs select-high run lengths.
  logic [31:0] rx_sh = '0;
  int          rx_bits = 0;
  int          hi_run = 0;
  int          mosi_hi_err = 0;
  logic [31:0] rx_q[$];
  int          gaps[$];

  always @(negedge clk_i) begin
    if (!rst_ni) begin
      rx_bits = 0;
      hi_run  = 0;
    end else if (!spi_ss_o) begin
      if (hi_run > 0) gaps.push_back(hi_run);
      hi_run  = 0;
      rx_sh   = {rx_sh[30:0], spi_mosi_o};
      rx_bits = rx_bits + 1;
      if (rx_bits == 32) begin
        rx_q.push_back(rx_sh);
        rx_bits = 0;
      end
    end else begin
      hi_run = hi_run + 1;
      if (spi_mosi_o !== 1'b0) mosi_hi_err = mosi_hi_err + 1;
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic push_word(input logic [31:0] d);
    int g = 0;
    valid_i = 1'b1;
    data_i  = d;
    while (!ready_o && g < 2000) begin
      @(negedge clk_i);
      g++;
    end
    if (!ready_o) begin
      n_total++;
      $display("FAIL push_word: ready_o stuck at %b, required 1", ready_o);
    end
    @(negedge clk_i);
    valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    int g = 0;
    while (busy_o && g < 5000) begin
      @(negedge clk_i);
      g++;
    end
    if (busy_o) begin
      n_total++;
      $display("FAIL wait_idle: busy_o=%b after %0d cycles, required 0", busy_o, g);
    end
  endtask

  typedef struct {
    logic [31:0] data;
    logic [31:0] exp_rx;
    logic [15:0] exp_count;
  } vec_t;

  vec_t        vecs[4];
  logic [31:0] bits;
  int          low_cnt;
  logic [31:0] full_w[6];
  logic [31:0] lb_w[8];
  int          idx, first_low, guard;
  logic        acc;

  initial begin
    vecs[0] = '{32'h0000_0000, 32'h0000_0000, 16'd2};
    vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 16'd3};
    vecs[2] = '{32'h8000_0001, 32'h8000_0001, 16'd4};
    vecs[3] = '{32'h6996_C33C, 32'h6996_C33C, 16'd5};
    full_w  = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333,
                32'h4444_4444, 32'h5555_5555, 32'h6666_6666};
    lb_w    = '{32'h0123_4567, 32'h89AB_CDEF, 32'hFEDC_BA98, 32'h7654_3210,
                32'hAAAA_5555, 32'h5555_AAAA, 32'h00FF_00FF, 32'hF0F0_F0F0};

    rst_ni  = 1'b1;
    valid_i = 1'b0;
    data_i  = '0;
    #1 rst_ni = 1'b0;
    #1;
    check("reset ss", spi_ss_o, 1);
    check("reset mosi", spi_mosi_o, 0);
    check("reset ready", ready_o, 1);
    check("reset busy", busy_o, 0);
    check("reset count", words_sent_o, 0);
    repeat (2) @(negedge clk_i);
    #2 rst_ni = 1'b1;
    @(negedge clk_i);

    // Single word with exact edge timing: accepted at edge t.
    valid_i = 1'b1;
    data_i  = 32'hA5A5_0F0F;
    @(negedge clk_i);
    valid_i = 1'b0;
    check("t ss still high", spi_ss_o, 1);
    check("t busy", busy_o, 1);
    bits    = '0;
    low_cnt = 0;
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk_i);
      if (!spi_ss_o) low_cnt++;
      bits = {bits[30:0], spi_mosi_o};
    end
    check("single ss low cycles", low_cnt, 32);
    check("single mosi word", bits, 32'hA5A5_0F0F);
    @(negedge clk_i);
    check("t+33 ss", spi_ss_o, 1);
    check("t+33 mosi", spi_mosi_o, 0);
    check("t+33 count", words_sent_o, 1);
    @(negedge clk_i);
    check("t+34 busy in gap", busy_o, 1);
    @(negedge clk_i);
    check("t+35 idle", busy_o, 0);
    rx_q.delete();

    for (int i = 0; i < 4; i++) begin
      rx_q.delete();
      push_word(vecs[i].data);
      wait_idle();
      check("vec rx size", rx_q.size(), 1);
      check("vec rx word", rx_q[0], vecs[i].exp_rx);
      check("vec count", words_sent_o, {16'h0, vecs[i].exp_count});
    end

    // Back-to-back frames.
    rx_q.delete();
    push_word(32'h0000_0001);
    push_word(32'h8000_0000);
    wait_idle();
    check("b2b rx size", rx_q.size(), 2);
    check("b2b first lsb", rx_q[0][0], 1);
    check("b2b second msb", rx_q[1][31], 1);
    check("b2b first word", rx_q[0], 32'h0000_0001);
    check("b2b second word", rx_q[1], 32'h8000_0000);
    check("b2b gap", gaps[$], 2);
    check("b2b count", words_sent_o, 7);

    // FIFO full: valid held high across six words.
    rx_q.delete();
    idx       = 0;
    first_low = -1;
    guard     = 0;
    valid_i   = 1'b1;
    data_i    = full_w[0];
    while (idx < 6 && guard < 1000) begin
      acc = ready_o;
      if (!ready_o && first_low < 0) first_low = idx;
      @(negedge clk_i);
      guard++;
      if (acc) begin
        idx++;
        if (idx < 6) data_i = full_w[idx];
      end
    end
    valid_i = 1'b0;
    check("full all accepted", idx, 6);
    // One word in the shifter plus four buffered.
    check("full ready drop point", first_low, 5);
    wait_idle();
    check("full rx size", rx_q.size(), 6);
    for (int i = 0; i < 6; i++) check("full order", rx_q[i], full_w[i]);
    check("full count", words_sent_o, 13);
    check("full ready back", ready_o, 1);

    // Reset ten bits into a frame with two more words buffered.
    rx_q.delete();
    push_word(32'hDEAD_BEEF);
    push_word(32'hCAFE_F00D);
    push_word(32'h0BAD_C0DE);
    repeat (8) @(negedge clk_i);
    #2;
    check("bits before reset", rx_bits, 10);
    rst_ni = 1'b0;
    #1;
    check("mid reset ss", spi_ss_o, 1);
    check("mid reset mosi", spi_mosi_o, 0);
    check("mid reset busy", busy_o, 0);
    check("mid reset ready", ready_o, 1);
    check("mid reset count", words_sent_o, 0);
    @(negedge clk_i);
    #2 rst_ni = 1'b1;
    @(negedge clk_i);
    @(negedge clk_i);
    check("post reset idle", busy_o, 0);
    check("post reset no frames", rx_q.size(), 0);
    push_word(32'h1234_5678);
    wait_idle();
    check("post reset rx size", rx_q.size(), 1);
    check("post reset rx word", rx_q[0], 32'h1234_5678);
    check("post reset count", words_sent_o, 1);

    // Counter wrap.
    rx_q.delete();
    force dut.words_sent_q = 16'hFFFF;
    @(negedge clk_i);
    release dut.words_sent_q;
    @(negedge clk_i);
    check("wrap preload", words_sent_o, 16'hFFFF);
    push_word(32'h5A5A_5A5A);
    wait_idle();
    check("wrap count", words_sent_o, 16'h0000);
    check("wrap rx word", rx_q[0], 32'h5A5A_5A5A);

    // Loopback of eight words.
    rx_q.delete();
    for (int i = 0; i < 8; i++) push_word(lb_w[i]);
    wait_idle();
    check("loop rx size", rx_q.size(), 8);
    for (int i = 0; i < 8; i++) check("loop order", rx_q[i], lb_w[i]);
    check("loop count", words_sent_o, 8);

    check("mosi low while ss high", mosi_hi_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
